// File: rtl/alu_chk_pkg.sv
// Shared opcodes, FSM states and first-mismatch record layout for alu_result_checker.
package alu_chk_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;
    // {sel, a, b, got, exp, got_c, exp_c}
    localparam int unsigned REC_W  = SEL_W + 4 * DATA_W + 2;

    localparam logic [SEL_W-1:0] OP_ADD  = 4'h0;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'h1;
    localparam logic [SEL_W-1:0] OP_MUL  = 4'h2;
    localparam logic [SEL_W-1:0] OP_DIV  = 4'h3;
    localparam logic [SEL_W-1:0] OP_SHL  = 4'h4;
    localparam logic [SEL_W-1:0] OP_SHR  = 4'h5;
    localparam logic [SEL_W-1:0] OP_ROL  = 4'h6;
    localparam logic [SEL_W-1:0] OP_ROR  = 4'h7;
    localparam logic [SEL_W-1:0] OP_AND  = 4'h8;
    localparam logic [SEL_W-1:0] OP_OR   = 4'h9;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'hA;
    localparam logic [SEL_W-1:0] OP_NOR  = 4'hB;
    localparam logic [SEL_W-1:0] OP_NAND = 4'hC;
    localparam logic [SEL_W-1:0] OP_XNOR = 4'hD;
    localparam logic [SEL_W-1:0] OP_GT   = 4'hE;
    localparam logic [SEL_W-1:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } chk_state_e;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] exp;
        logic              got_c;
        logic              exp_c;
    } err_rec_t;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference of the 8-bit, 16-op alu: expected result, carry and compare enable.
module alu_golden_model
    import alu_chk_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] exp_out,
    output logic              exp_c,
    output logic              cmp_en
);

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        prod    = {8'h00, a} * {8'h00, b};
        // The alu reports the adder carry regardless of the selected op
        exp_c   = sum[DATA_W];
        cmp_en  = !((sel == OP_DIV) && (b == 8'h00));
        exp_out = '0;
        case (sel)
            OP_ADD:  exp_out = sum[DATA_W-1:0];
            OP_SUB:  exp_out = a - b;
            OP_MUL:  exp_out = prod[DATA_W-1:0];
            OP_DIV:  exp_out = (b == 8'h00) ? 8'h00 : a / b;
            OP_SHL:  exp_out = {a[6:0], 1'b0};
            OP_SHR:  exp_out = {1'b0, a[7:1]};
            OP_ROL:  exp_out = {a[6:0], a[7]};
            OP_ROR:  exp_out = {a[0], a[7:1]};
            OP_AND:  exp_out = a & b;
            OP_OR:   exp_out = a | b;
            OP_XOR:  exp_out = a ^ b;
            OP_NOR:  exp_out = ~(a | b);
            OP_NAND: exp_out = ~(a & b);
            OP_XNOR: exp_out = ~(a ^ b);
            OP_GT:   exp_out = {7'h00, (a > b)};
            OP_EQ:   exp_out = {7'h00, (a == b)};
            default: exp_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// Checks observed alu beats against a 2-stage golden pipeline; counts checked/error/skipped
// beats and latches the first mismatching beat.
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    input  logic [3:0]        in_sel,
    input  logic [7:0]        in_out,
    input  logic              in_carry,
    output logic [CNT_W-1:0]  checked_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  skip_cnt,
    output logic              first_err_vld,
    output logic [REC_W-1:0]  first_err_rec,
    output logic              done,
    output logic              pass
);

    localparam int unsigned ACC_W = $clog2(NUM_VECTORS + 1);
    localparam logic [ACC_W-1:0] LAST_BEAT = ACC_W'(NUM_VECTORS - 1);

    chk_state_e state_q, state_d;
    logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;
    logic accept, capture;

    // Stage 0: raw observed beat
    logic              p0_vld_q;
    logic [DATA_W-1:0] p0_a_q, p0_b_q, p0_got_q;
    logic [SEL_W-1:0]  p0_sel_q;
    logic              p0_got_c_q;

    // Stage 1: beat plus registered golden result
    logic     p1_vld_q;
    logic     p1_cmp_en_q;
    err_rec_t p1_rec_q;
    logic     mismatch;

    logic [DATA_W-1:0] g_exp;
    logic              g_exp_c;
    logic              g_cmp_en;

    logic [CNT_W-1:0] checked_q, err_q, skip_q;
    logic             rec_vld_q;
    err_rec_t         rec_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    alu_golden_model u_golden (
        .a       (p0_a_q),
        .b       (p0_b_q),
        .sel     (p0_sel_q),
        .exp_out (g_exp),
        .exp_c   (g_exp_c),
        .cmp_en  (g_cmp_en)
    );

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        in_ready  = (state_q == StRun);
        accept    = in_valid & in_ready;
        // A beat presented alongside start is dropped with the rest of the run
        capture   = accept & ~start;
        if (start) begin
            state_d   = StRun;
            acc_cnt_d = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept) begin
                        acc_cnt_d = acc_cnt_q + ACC_W'(1);
                        if (acc_cnt_q == LAST_BEAT) state_d = StDrain;
                    end
                end
                StDrain: begin
                    if (!p0_vld_q && !p1_vld_q) state_d = StDone;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mismatch = (p1_rec_q.got != p1_rec_q.exp) || (p1_rec_q.got_c != p1_rec_q.exp_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_cnt_q   <= '0;
            p0_vld_q    <= 1'b0;
            p0_a_q      <= '0;
            p0_b_q      <= '0;
            p0_got_q    <= '0;
            p0_sel_q    <= '0;
            p0_got_c_q  <= 1'b0;
            p1_vld_q    <= 1'b0;
            p1_cmp_en_q <= 1'b0;
            p1_rec_q    <= '0;
            checked_q   <= '0;
            err_q       <= '0;
            skip_q      <= '0;
            rec_vld_q   <= 1'b0;
            rec_q       <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;

            p0_vld_q <= capture;
            if (capture) begin
                p0_a_q     <= in_a;
                p0_b_q     <= in_b;
                p0_got_q   <= in_out;
                p0_sel_q   <= in_sel;
                p0_got_c_q <= in_carry;
            end

            p1_vld_q <= p0_vld_q & ~start;
            if (p0_vld_q) begin
                p1_cmp_en_q <= g_cmp_en;
                p1_rec_q    <= '{sel: p0_sel_q, a: p0_a_q, b: p0_b_q, got: p0_got_q,
                                 exp: g_exp, got_c: p0_got_c_q, exp_c: g_exp_c};
            end

            if (start) begin
                checked_q <= '0;
                err_q     <= '0;
                skip_q    <= '0;
                rec_vld_q <= 1'b0;
                rec_q     <= '0;
            end else if (p1_vld_q) begin
                if (!p1_cmp_en_q) begin
                    skip_q <= sat_inc(skip_q);
                end else begin
                    checked_q <= sat_inc(checked_q);
                    if (mismatch) begin
                        err_q <= sat_inc(err_q);
                        if (!rec_vld_q) begin
                            rec_vld_q <= 1'b1;
                            rec_q     <= p1_rec_q;
                        end
                    end
                end
            end
        end
    end

    assign checked_cnt   = checked_q;
    assign err_cnt       = err_q;
    assign skip_cnt      = skip_q;
    assign first_err_vld = rec_vld_q;
    assign first_err_rec = rec_q;
    assign done          = (state_q == StDone);
    assign pass          = (state_q == StDone) && (err_q == '0);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed and randomized self-checking bench for alu_result_checker with an arithmetic reference.
module tb_alu_result_checker;
    import alu_chk_pkg::*;

    localparam int unsigned NV = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0, in_b = '0, in_out = '0;
    logic [3:0]       in_sel = '0;
    logic             in_carry = 1'b0;
    logic [7:0]       checked_cnt, err_cnt, skip_cnt;
    logic             first_err_vld;
    logic [REC_W-1:0] first_err_rec;
    logic             done, pass;

    int errors = 0;
    int checks = 0;
    bit bubbles = 1'b0;

    int               m_checked, m_err, m_skip;
    logic             m_vld;
    logic [REC_W-1:0] m_rec;

    always #5 clk = ~clk;

    alu_result_checker #(.NUM_VECTORS(NV), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_sel        (in_sel),
        .in_out        (in_out),
        .in_carry      (in_carry),
        .checked_cnt   (checked_cnt),
        .err_cnt       (err_cnt),
        .skip_cnt      (skip_cnt),
        .first_err_vld (first_err_vld),
        .first_err_rec (first_err_rec),
        .done          (done),
        .pass          (pass)
    );

    // Returns {carry, result} from plain integer arithmetic on the op table
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
        int unsigned ia = a;
        int unsigned ib = b;
        int unsigned r;
        case (sel)
            4'h0:    r = ia + ib;
            4'h1:    r = ia + 256 - ib;
            4'h2:    r = ia * ib;
            4'h3:    r = (ib == 0) ? 0 : ia / ib;
            4'h4:    r = ia * 2;
            4'h5:    r = ia / 2;
            4'h6:    r = ia * 2 + ia / 128;
            4'h7:    r = ia / 2 + (ia % 2) * 128;
            4'h8:    r = ia & ib;
            4'h9:    r = ia | ib;
            4'hA:    r = ia ^ ib;
            4'hB:    r = 255 - (ia | ib);
            4'hC:    r = 255 - (ia & ib);
            4'hD:    r = 255 - (ia ^ ib);
            4'hE:    r = (ia > ib) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        return {((ia + ib) > 255) ? 1'b1 : 1'b0, 8'(r % 256)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_checked = 0;
        m_err     = 0;
        m_skip    = 0;
        m_vld     = 1'b0;
        m_rec     = '0;
    endtask

    task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                              input logic [7:0] o, input logic c);
        logic [8:0] r;
        r = ref_alu(a, b, sel);
        if (sel == 4'h3 && b == 8'h00) begin
            m_skip++;
        end else begin
            m_checked++;
            if (o !== r[7:0] || c !== r[8]) begin
                m_err++;
                if (!m_vld) begin
                    m_vld = 1'b1;
                    m_rec = {sel, a, b, o, r[7:0], c, r[8]};
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input logic [7:0] o, input logic c);
        if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk);
        in_a = a; in_b = b; in_sel = sel; in_out = o; in_carry = c;
        in_valid = 1'b1;
        for (int g = 0; g < 40 && !in_ready; g++) @(negedge clk);
        check("in_ready_before_beat", in_ready, 1'b1);
        @(posedge clk);
        if (in_ready) model_beat(a, b, sel, o, c);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit allow_bad);
        logic [7:0] a, b, o;
        logic [3:0] sel;
        logic [8:0] r;
        logic       c;
        a   = 8'($urandom);
        b   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        sel = 4'($urandom);
        r   = ref_alu(a, b, sel);
        o   = r[7:0];
        c   = r[8];
        if (allow_bad && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) o = o ^ 8'($urandom_range(1, 255));
            else c = ~c;
        end
        send(a, b, sel, o, c);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_checked"}, checked_cnt, 64'(m_checked));
        check({tag, "_err"}, err_cnt, 64'(m_err));
        check({tag, "_skip"}, skip_cnt, 64'(m_skip));
        check({tag, "_rec_vld"}, first_err_vld, m_vld);
        check({tag, "_rec"}, first_err_rec, m_rec);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 30 && !done; n++) @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check_counts(tag);
        check({tag, "_pass"}, pass, (m_err == 0));
    endtask

    initial begin
        logic [8:0] r;
        model_clear();

        // Reset with junk on the inputs
        in_valid = 1'b1;
        in_a = 8'h55;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check_counts("rst");

        // Beats offered in IDLE are ignored
        idle_cycles(3);
        in_valid = 1'b0;
        check_counts("idle_ignore");
        pulse_start();
        check("start_in_ready", in_ready, 1'b1);

        // Clean sweep of every opcode
        for (int s = 0; s < 16; s++) begin
            r = ref_alu(8'h0A, 8'h02, 4'(s));
            send(8'h0A, 8'h02, 4'(s), r[7:0], r[8]);
        end
        wait_done("sweep");
        check("sweep_checked16", checked_cnt, 8'd16);

        // Wrap and carry
        pulse_start();
        check_counts("restart_clear");
        send(8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1);
        idle_cycles(3);
        check("wrap_ok_err", err_cnt, 8'd0);
        send(8'hF6, 8'h0A, 4'h0, 8'h00, 1'b0);
        idle_cycles(3);
        check("carry_bad_err", err_cnt, 8'd1);
        for (int i = 0; i < 14; i++) send_rand(1'b0);
        wait_done("wrap");

        // First-error latch holds the earlier mismatch
        pulse_start();
        send(8'h0A, 8'h02, 4'h8, 8'hFF, 1'b0);
        send(8'h0A, 8'h02, 4'h9, 8'h00, 1'b0);
        for (int i = 0; i < 14; i++) send_rand(1'b0);
        wait_done("latch");
        check("latch_err2", err_cnt, 8'd2);
        check("latch_rec_fixed", first_err_rec,
              {4'h8, 8'h0A, 8'h02, 8'hFF, 8'h02, 1'b0, 1'b0});

        // Divide by zero is skipped
        pulse_start();
        send(8'h37, 8'h00, 4'h3, 8'h5A, 1'b0);
        idle_cycles(3);
        check("div0_skip", skip_cnt, 8'd1);
        check("div0_checked", checked_cnt, 8'd0);
        check("div0_err", err_cnt, 8'd0);
        for (int i = 0; i < 15; i++) send_rand(1'b1);
        wait_done("div0");

        // Random run with bubbles and corruption
        bubbles = 1'b1;
        pulse_start();
        for (int i = 0; i < 16; i++) send_rand(1'b1);
        wait_done("rand1");

        // start mid-run flushes the pipe and clears everything
        pulse_start();
        for (int i = 0; i < 5; i++) send_rand(1'b1);
        pulse_start();
        check_counts("abort_clear");
        idle_cycles(3);
        check_counts("abort_flushed");
        for (int i = 0; i < 16; i++) send_rand(1'b1);
        wait_done("rand2");

        // rst while draining returns to IDLE
        pulse_start();
        for (int i = 0; i < 16; i++) send_rand(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("rst_drain_ready", in_ready, 1'b0);
        check("rst_drain_done", done, 1'b0);
        check_counts("rst_drain");
        in_valid = 1'b1;
        idle_cycles(5);
        in_valid = 1'b0;
        check("rst_drain_idle_done", done, 1'b0);
        check("rst_drain_idle_ready", in_ready, 1'b0);
        check_counts("rst_drain_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
